channel_op_arbiter: RTL and testbench
=====================================

CHANNEL_OP_ARBITER -- requirements
Module: channel_op_arbiter

Interface
REQ-001 The block SHALL have parameter addrBits, default `ADDRESS_BITS, meaning channel RAM address width.
REQ-002 The block SHALL have parameter dataBits, default `DATA_BITS, meaning channel RAM data width.
REQ-003 The block SHALL have parameter timeoutCycles, default 64, meaning the RUN-state cycle limit, used only when the timeout macro is defined.
REQ-004 The block SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset  input  1  meaning the reset: asynchronous, active-low.
REQ-006 The block SHALL have port req  input  4  meaning per-unit request for the channel RAM (Enable, Disable, Send, Receive units).
REQ-007 The block SHALL have port unitAddress  input  4*addrBits  meaning per-unit RAM address; unit i in slice i.
REQ-008 The block SHALL have port unitReadWriteMode  input  4  meaning per-unit `RAM_READ/`RAM_WRITE.
REQ-009 The block SHALL have port unitDataIn  input  4*dataBits  meaning per-unit write data.
REQ-010 The block SHALL have port unitFinished  input  4  meaning per-unit completion pulse.
REQ-011 The block SHALL have port unitRun  output  4  meaning per-unit active-low run/reset; high only while the unit is granted.
REQ-012 The block SHALL have port grant  output  4  meaning one-hot grant; registered.
REQ-013 The block SHALL have port done  output  4  meaning one-cycle completion pulse to the requester.
REQ-014 The block SHALL have port address  output  addrBits  meaning the RAM address.
REQ-015 The block SHALL have port readWriteMode  output  1  meaning the RAM direction.
REQ-016 The block SHALL have port dataIn  output  dataBits  meaning the RAM write data.
REQ-017 The block SHALL have port dataOut  input  dataBits  meaning RAM read data; passed unregistered to unitDataOut.
REQ-018 The block SHALL have port unitDataOut  output  dataBits  meaning read data broadcast to all units.
REQ-019 The block SHALL have port busy  output  1  meaning state is not IDLE.

Function
REQ-020 The block SHALL implement states IDLE, RUN and RELEASE.
REQ-021 IDLE, req nonzero SHALL select the first set bit at or after rrPtr (wrapping 3 to 0), register the one-hot grant, and enter RUN; unitRun[g] goes high the cycle after req is sampled.
REQ-022 IDLE, req zero SHALL remain in IDLE with grant 0.
REQ-023 In RUN, address, readWriteMode and dataIn SHALL be combinationally muxed from the granted unit's slice.
REQ-024 In RUN, changes on req SHALL be ignored; grant SHALL be held until unitFinished[g].
REQ-025 unitFinished on a non-granted unit SHALL be ignored.
REQ-026 RUN with unitFinished[g]=1 SHALL enter RELEASE.
REQ-027 RELEASE SHALL drive grant=0, unitRun=0, done[g]=1 for exactly that cycle, set rrPtr=(g+1) mod 4, and return to IDLE.
REQ-028 The minimum occupancy SHALL be IDLE+RUN+RELEASE, and no unit SHALL receive two consecutive grants while another requests.
REQ-029 Outside RUN, address SHALL be 0, dataIn SHALL be 0 and readWriteMode SHALL be `RAM_READ; no RAM write is possible.
REQ-030 A requester SHALL hold req until it observes done; the arbiter SHALL re-grant a held req after other pending units are served.

Reset
REQ-031 On reset low, the block SHALL immediately set state IDLE, rrPtr=0, grant=0, unitRun=0, done=0, busy=0, and the timeout counter and flags to 0.
REQ-032 Reset mid-RUN SHALL abandon the operation with no done pulse; the unit is held in reset via unitRun=0.

Configuration
REQ-033 With macro CHANNEL_ARB_TIMEOUT_EN defined, the block SHALL add outputs timeoutError (1, sticky until reset) and timeoutUnit (2 bits), and a RUN cycle counter cleared on RUN entry.
REQ-034 With the macro defined, a counter reaching timeoutCycles without unitFinished SHALL force RELEASE with done[g] pulsed, timeoutError=1 and timeoutUnit=g.
REQ-035 Without the macro, those ports and the counter SHALL be absent and RUN SHALL be unbounded.

Verification
REQ-036 The bench SHALL cover: req=0010 in IDLE -> grant=0010 and unitRun=0010 next cycle; unit1 address 0x05 write 0x0007 appears on the RAM bus; finished -> done=0010 for 1 cycle, then IDLE.
REQ-037 The bench SHALL cover: req=1111 held throughout, rrPtr=0 -> grant order 0,1,2,3,0 with done pulses in that order.
REQ-038 The bench SHALL cover: unit2 granted, unitFinished=0001 pulsed -> ignored, grant stays 0100; unitFinished=0100 -> RELEASE.
REQ-039 The bench SHALL cover: reset low mid-RUN (unit3) -> all outputs 0 without a clock edge, no done; after release req=1000 is re-granted.
REQ-040 The bench SHALL cover, with CHANNEL_ARB_TIMEOUT_EN defined and timeoutCycles=8: unit0 never finishes -> RELEASE after 8 RUN cycles, done=0001, timeoutError=1, timeoutUnit=0.
REQ-041 The bench SHALL cover: readWriteMode in IDLE and RELEASE -> always `RAM_READ across all scenarios.

Source files
------------

// File: rtl/channel_op_arbiter_if.sv
// Bus bundle between the channel RAM arbiter and its four requesting units plus the RAM.
// The optional timeout status signals exist only when CHANNEL_ARB_TIMEOUT_EN is defined.
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 16
`endif
`ifndef RAM_READ
`define RAM_READ 1'b0
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 1'b1
`endif

interface channel_op_arbiter_if #(
    parameter int addrBits = `ADDRESS_BITS,
    parameter int dataBits = `DATA_BITS
);
    logic [3:0]            req;
    logic [4*addrBits-1:0] unitAddress;
    logic [3:0]            unitReadWriteMode;
    logic [4*dataBits-1:0] unitDataIn;
    logic [3:0]            unitFinished;
    logic [3:0]            unitRun;
    logic [3:0]            grant;
    logic [3:0]            done;
    logic [addrBits-1:0]   address;
    logic                  readWriteMode;
    logic [dataBits-1:0]   dataIn;
    logic [dataBits-1:0]   dataOut;
    logic [dataBits-1:0]   unitDataOut;
    logic                  busy;
`ifdef CHANNEL_ARB_TIMEOUT_EN
    logic                  timeoutError;
    logic [1:0]            timeoutUnit;

    modport slave (
        input  req, unitAddress, unitReadWriteMode, unitDataIn, unitFinished, dataOut,
        output unitRun, grant, done, address, readWriteMode, dataIn, unitDataOut, busy,
               timeoutError, timeoutUnit
    );
    modport master (
        output req, unitAddress, unitReadWriteMode, unitDataIn, unitFinished, dataOut,
        input  unitRun, grant, done, address, readWriteMode, dataIn, unitDataOut, busy,
               timeoutError, timeoutUnit
    );
`else
    modport slave (
        input  req, unitAddress, unitReadWriteMode, unitDataIn, unitFinished, dataOut,
        output unitRun, grant, done, address, readWriteMode, dataIn, unitDataOut, busy
    );
    modport master (
        output req, unitAddress, unitReadWriteMode, unitDataIn, unitFinished, dataOut,
        input  unitRun, grant, done, address, readWriteMode, dataIn, unitDataOut, busy
    );
`endif
endinterface

// File: rtl/channel_op_arbiter.sv
// Round-robin arbiter giving one of four units exclusive use of the channel RAM.
// Define CHANNEL_ARB_TIMEOUT_EN to bound RUN to timeoutCycles and flag a stuck unit.
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 16
`endif
`ifndef RAM_READ
`define RAM_READ 1'b0
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 1'b1
`endif

module channel_op_arbiter #(
    parameter int addrBits      = `ADDRESS_BITS,
    parameter int dataBits      = `DATA_BITS,
    parameter int timeoutCycles = 64
) (
    input  logic                clk,
    input  logic                reset,
    channel_op_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;

    state_t     state;
    logic [3:0] grantR;
    logic [3:0] unitRunR;
    logic [3:0] doneR;
    logic [1:0] rrPtr;
    logic [1:0] gIdx;
    logic       busyR;
    logic [1:0] nextIdx;
    logic       releaseNow;

    if (timeoutCycles < 1) begin : gBadTimeout
        $error("channel_op_arbiter: timeoutCycles must be at least 1");
    end

    // First requesting unit at or after the pointer, wrapping 3 -> 0.
    function automatic logic [1:0] pickNext(input logic [3:0] r, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] sel;
        logic       found;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && r[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [3:0] oneHot(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    assign nextIdx = pickNext(bus.req, rrPtr);

`ifdef CHANNEL_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(timeoutCycles + 1);

    logic [CntW-1:0] runCount;
    logic            timeoutHit;
    logic            timeoutErrorR;
    logic [1:0]      timeoutUnitR;

    assign timeoutHit       = (runCount == CntW'(timeoutCycles - 1));
    assign releaseNow       = (state == RUN) && (bus.unitFinished[gIdx] || timeoutHit);
    assign bus.timeoutError = timeoutErrorR;
    assign bus.timeoutUnit  = timeoutUnitR;
`else
    assign releaseNow = (state == RUN) && bus.unitFinished[gIdx];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grantR   <= '0;
            unitRunR <= '0;
            doneR    <= '0;
            rrPtr    <= '0;
            gIdx     <= '0;
            busyR    <= 1'b0;
`ifdef CHANNEL_ARB_TIMEOUT_EN
            runCount      <= '0;
            timeoutErrorR <= 1'b0;
            timeoutUnitR  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    doneR <= '0;
                    if (|bus.req) begin
                        grantR   <= oneHot(nextIdx);
                        unitRunR <= oneHot(nextIdx);
                        gIdx     <= nextIdx;
                        busyR    <= 1'b1;
                        state    <= RUN;
`ifdef CHANNEL_ARB_TIMEOUT_EN
                        runCount <= '0;
`endif
                    end
                end
                RUN: begin
                    if (releaseNow) begin
                        grantR   <= '0;
                        unitRunR <= '0;
                        doneR    <= oneHot(gIdx);
                        rrPtr    <= gIdx + 2'd1;
                        state    <= RELEASE;
`ifdef CHANNEL_ARB_TIMEOUT_EN
                        if (!bus.unitFinished[gIdx]) begin
                            timeoutErrorR <= 1'b1;
                            timeoutUnitR  <= gIdx;
                        end
                    end else begin
                        runCount <= runCount + 1'b1;
`endif
                    end
                end
                RELEASE: begin
                    doneR <= '0;
                    busyR <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The RAM bus follows the granted unit only in RUN; elsewhere it is parked on a read.
    always_comb begin
        bus.address       = '0;
        bus.readWriteMode = `RAM_READ;
        bus.dataIn        = '0;
        if (state == RUN) begin
            bus.address       = bus.unitAddress[gIdx*addrBits +: addrBits];
            bus.readWriteMode = bus.unitReadWriteMode[gIdx];
            bus.dataIn        = bus.unitDataIn[gIdx*dataBits +: dataBits];
        end
    end

    assign bus.grant       = grantR;
    assign bus.unitRun     = unitRunR;
    assign bus.done        = doneR;
    assign bus.busy        = busyR;
    assign bus.unitDataOut = bus.dataOut;
endmodule

// File: tb/tb_channel_op_arbiter.sv
// Directed bench for channel_op_arbiter: single grant, round robin, ignored finishes,
// async reset mid-RUN, and the RUN timeout when CHANNEL_ARB_TIMEOUT_EN is defined.
`ifndef RAM_READ
`define RAM_READ 1'b0
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 1'b1
`endif

module tb_channel_op_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 8;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    channel_op_arbiter_if #(.addrBits(AW), .dataBits(DW)) bus ();

    channel_op_arbiter #(.addrBits(AW), .dataBits(DW), .timeoutCycles(TO)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] order [5];
        checks   = 0;
        failures = 0;
        order    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        reset                 = 1'b1;
        bus.req               = '0;
        bus.unitAddress       = '0;
        bus.unitReadWriteMode = '0;
        bus.unitDataIn        = '0;
        bus.unitFinished      = '0;
        bus.dataOut           = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_unitRun", 32'(bus.unitRun), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_rwm", 32'(bus.readWriteMode), 32'(`RAM_READ));
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("idle_grant", 32'(bus.grant), 32'h0);
        chk("idle_busy", 32'(bus.busy), 32'h0);

        // Round robin with all four units requesting from rrPtr=0.
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_grant", 32'(bus.grant), 32'(4'b0001 << order[i]));
            chk("rr_unitRun", 32'(bus.unitRun), 32'(4'b0001 << order[i]));
            chk("rr_busy", 32'(bus.busy), 32'h1);
            bus.unitFinished = 4'b0001 << order[i];
            tick();
            bus.unitFinished = '0;
            chk("rr_done", 32'(bus.done), 32'(4'b0001 << order[i]));
            chk("rr_rel_grant", 32'(bus.grant), 32'h0);
            chk("rr_rel_rwm", 32'(bus.readWriteMode), 32'(`RAM_READ));
            tick();
            chk("rr_idle_done", 32'(bus.done), 32'h0);
            chk("rr_idle_rwm", 32'(bus.readWriteMode), 32'(`RAM_READ));
        end
        bus.req = '0;
        tick();

        // Unit 1 writes 0x0007 to address 0x05.
        bus.req                  = 4'b0010;
        bus.unitAddress[AW +: AW] = 8'h05;
        bus.unitDataIn[DW +: DW]  = 16'h0007;
        bus.unitReadWriteMode    = 4'b0010;
        bus.dataOut              = 16'hABCD;
        chk("u1_pre_grant", 32'(bus.grant), 32'h0);
        chk("u1_pre_addr", 32'(bus.address), 32'h0);
        tick();
        chk("u1_grant", 32'(bus.grant), 32'h2);
        chk("u1_unitRun", 32'(bus.unitRun), 32'h2);
        chk("u1_addr", 32'(bus.address), 32'h05);
        chk("u1_rwm", 32'(bus.readWriteMode), 32'(`RAM_WRITE));
        chk("u1_dataIn", 32'(bus.dataIn), 32'h0007);
        chk("u1_dataOut", 32'(bus.unitDataOut), 32'hABCD);
        bus.unitFinished = 4'b0010;
        tick();
        bus.unitFinished = '0;
        bus.req          = '0;
        chk("u1_done", 32'(bus.done), 32'h2);
        chk("u1_rel_grant", 32'(bus.grant), 32'h0);
        chk("u1_rel_unitRun", 32'(bus.unitRun), 32'h0);
        chk("u1_rel_addr", 32'(bus.address), 32'h0);
        chk("u1_rel_dataIn", 32'(bus.dataIn), 32'h0);
        chk("u1_rel_rwm", 32'(bus.readWriteMode), 32'(`RAM_READ));
        tick();
        chk("u1_idle_done", 32'(bus.done), 32'h0);
        chk("u1_idle_busy", 32'(bus.busy), 32'h0);
        bus.unitReadWriteMode = '0;

        // Unit 2: finish from a non-granted unit and req changes are ignored.
        bus.req = 4'b0100;
        tick();
        chk("u2_grant", 32'(bus.grant), 32'h4);
        bus.unitFinished = 4'b0001;
        bus.req          = 4'b1111;
        tick();
        chk("u2_hold_grant", 32'(bus.grant), 32'h4);
        chk("u2_hold_done", 32'(bus.done), 32'h0);
        bus.unitFinished = 4'b0100;
        tick();
        bus.unitFinished = '0;
        bus.req          = '0;
        chk("u2_done", 32'(bus.done), 32'h4);
        chk("u2_rel_grant", 32'(bus.grant), 32'h0);
        tick();

        // Unit 3: asynchronous reset mid-RUN, then re-grant of the held request.
        bus.req = 4'b1000;
        tick();
        chk("u3_grant", 32'(bus.grant), 32'h8);
        #2 reset = 1'b0;
        #1;
        chk("u3_rst_grant", 32'(bus.grant), 32'h0);
        chk("u3_rst_unitRun", 32'(bus.unitRun), 32'h0);
        chk("u3_rst_done", 32'(bus.done), 32'h0);
        chk("u3_rst_busy", 32'(bus.busy), 32'h0);
        tick();
        chk("u3_rst_done_edge", 32'(bus.done), 32'h0);
        reset = 1'b1;
        tick();
        chk("u3_regrant", 32'(bus.grant), 32'h8);
        chk("u3_regrant_run", 32'(bus.unitRun), 32'h8);
        bus.unitFinished = 4'b1000;
        tick();
        bus.unitFinished = '0;
        bus.req          = '0;
        chk("u3_done", 32'(bus.done), 32'h8);
        tick();

        // Unit 0 never finishes.
        bus.req = 4'b0001;
        tick();
        chk("u0_grant", 32'(bus.grant), 32'h1);
`ifdef CHANNEL_ARB_TIMEOUT_EN
        chk("u0_tmo_err_pre", 32'(bus.timeoutError), 32'h0);
`endif
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            chk("u0_run_grant", 32'(bus.grant), 32'h1);
            chk("u0_run_done", 32'(bus.done), 32'h0);
        end
        tick();
`ifdef CHANNEL_ARB_TIMEOUT_EN
        bus.req = '0;
        chk("u0_tmo_done", 32'(bus.done), 32'h1);
        chk("u0_tmo_grant", 32'(bus.grant), 32'h0);
        chk("u0_tmo_err", 32'(bus.timeoutError), 32'h1);
        chk("u0_tmo_unit", 32'(bus.timeoutUnit), 32'h0);
        chk("u0_tmo_rwm", 32'(bus.readWriteMode), 32'(`RAM_READ));
        tick();
        chk("u0_tmo_idle_done", 32'(bus.done), 32'h0);
        chk("u0_tmo_sticky", 32'(bus.timeoutError), 32'h1);
`else
        chk("u0_unbounded_grant", 32'(bus.grant), 32'h1);
        chk("u0_unbounded_done", 32'(bus.done), 32'h0);
        bus.unitFinished = 4'b0001;
        tick();
        bus.unitFinished = '0;
        bus.req          = '0;
        chk("u0_done", 32'(bus.done), 32'h1);
        tick();
        chk("u0_idle_busy", 32'(bus.busy), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
